// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM states, word-length
// encoding, latched frame configuration and parity computation.
package uart_pkg;

   localparam int DIV_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam logic [1:0] BITLEN_5 = 2'b00;
   localparam logic [1:0] BITLEN_6 = 2'b01;
   localparam logic [1:0] BITLEN_7 = 2'b10;
   localparam logic [1:0] BITLEN_8 = 2'b11;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] bitlen;
      logic       par_en;
      logic       odd;
   } tx_cfg_t;

   function automatic logic [7:0] data_mask(input logic [1:0] bitlen);
      logic [7:0] mask;
      case (bitlen)
         BITLEN_5: mask = 8'h1F;
         BITLEN_6: mask = 8'h3F;
         BITLEN_7: mask = 8'h7F;
         BITLEN_8: mask = 8'hFF;
         default:  mask = 8'hFF;
      endcase
      return mask;
   endfunction

   // Index of the final data bit: N-1 for N = 5..8.
   function automatic logic [2:0] last_bit_idx(input logic [1:0] bitlen);
      return 3'd4 + {1'b0, bitlen};
   endfunction

   function automatic logic parity_bit(input tx_cfg_t cfg);
      return (^(cfg.data & data_mask(cfg.bitlen))) ^ cfg.odd;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts D cycles per bit (D = 0 behaves as 1) and emits a
// registered tick during the last cycle of every bit.
module uart_baud_gen
   import uart_pkg::*;
(
   input  logic             m_clock,
   input  logic             p_reset,
   input  logic             load_i,
   input  logic             run_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o,
   output logic             tick_next_o
);

   logic [DIV_W-1:0] div_m1;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      div_m1 = (div_i == '0) ? '0 : div_i - 1'b1;
      div_d  = div_q;
      cnt_d  = '0;
      if (load_i) begin
         div_d = div_m1;
         cnt_d = div_m1;
      end else if (run_i) begin
         cnt_d = (cnt_q == '0) ? div_q : cnt_q - 1'b1;
      end
      tick_d = (load_i || run_i) && (cnt_d == '0);
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         div_q  <= '0;
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o      = tick_q;
   assign tick_next_o = tick_d;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional parity, one
// stop bit. Configuration is captured when a frame is accepted; all outputs are flops.
module uart_tx
   import uart_pkg::*;
(
   input  logic             m_clock,
   input  logic             p_reset,
   input  logic [7:0]       Tx_Data_i,
   input  logic [DIV_W-1:0] Freq_Divide_Param_i,
   input  logic [1:0]       Tx_BitLength_i,
   input  logic             Tx_ParityEN_i,
   input  logic             Tx_OddParity_i,
   input  logic             Tx_Enable_i,
   input  logic             Tx_Start_i,
   output logic             TxD_o,
   output logic             Tx_Ready_o,
   output logic             Tx_ShiftClock_o,
   output logic             Tx_Finish_o
);

   tx_state_e state_q, state_d;
   tx_cfg_t   cfg_q, cfg_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic      txd_q, txd_d;
   logic      ready_q, ready_d;
   logic      finish_q, finish_d;
   logic      accept;
   logic      tick, tick_next;

   assign accept = (state_q == IDLE) && ready_q && Tx_Start_i;

   uart_baud_gen u_baud_gen (
      .m_clock     (m_clock),
      .p_reset     (p_reset),
      .load_i      (accept),
      .run_i       (state_d != IDLE),
      .div_i       (Freq_Divide_Param_i),
      .tick_o      (tick),
      .tick_next_o (tick_next)
   );

   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      bit_idx_d = bit_idx_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d       = START;
               cfg_d.data    = Tx_Data_i;
               cfg_d.bitlen  = Tx_BitLength_i;
               cfg_d.par_en  = Tx_ParityEN_i;
               cfg_d.odd     = Tx_OddParity_i;
               bit_idx_d     = '0;
            end
         end
         START: begin
            if (tick) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_idx_q == last_bit_idx(cfg_q.bitlen)) begin
                  state_d = cfg_q.par_en ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (tick) state_d = STOP;
         end
         STOP: begin
            if (tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the line changes on the same edge as the FSM.
   always_comb begin
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = cfg_d.data[bit_idx_d];
         PARITY:  txd_d = parity_bit(cfg_d);
         default: txd_d = 1'b1;
      endcase
      ready_d  = (state_d == IDLE) && Tx_Enable_i;
      finish_d = (state_d == STOP) && tick_next;
   end

   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         state_q   <= IDLE;
         cfg_q     <= '0;
         bit_idx_q <= '0;
         txd_q     <= 1'b1;
         ready_q   <= 1'b0;
         finish_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         bit_idx_q <= bit_idx_d;
         txd_q     <= txd_d;
         ready_q   <= ready_d;
         finish_q  <= finish_d;
      end
   end

   assign TxD_o           = txd_q;
   assign Tx_Ready_o      = ready_q;
   assign Tx_ShiftClock_o = tick;
   assign Tx_Finish_o     = finish_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of known frames, hand-written corner
// sequences, and randomized frames checked against a bit-list reference model.
module tb_uart_tx;

   logic        clk;
   logic        p_reset;
   logic [7:0]  tx_data;
   logic [15:0] freq;
   logic [1:0]  bitlen;
   logic        par_en;
   logic        odd_par;
   logic        en;
   logic        start;
   logic        txd;
   logic        rdy;
   logic        shclk;
   logic        fin;

   int n_vec = 0;
   int n_err = 0;

   uart_tx dut (
      .m_clock             (clk),
      .p_reset             (p_reset),
      .Tx_Data_i           (tx_data),
      .Freq_Divide_Param_i (freq),
      .Tx_BitLength_i      (bitlen),
      .Tx_ParityEN_i       (par_en),
      .Tx_OddParity_i      (odd_par),
      .Tx_Enable_i         (en),
      .Tx_Start_i          (start),
      .TxD_o               (txd),
      .Tx_Ready_o          (rdy),
      .Tx_ShiftClock_o     (shclk),
      .Tx_Finish_o         (fin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  data;
      logic [15:0] div;
      logic [1:0]  bl;
      logic        pen;
      logic        odd;
      int          hold;
      logic [10:0] pat;   // expected line bits, index 0 = start bit
      int          nb;
      int          len;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the frame as a list of line levels, straight from the framing rules.
   function automatic void build_pat(input logic [7:0] data, input logic [1:0] bl,
                                     input logic pen, input logic odd,
                                     output logic [10:0] pat, output int nb);
      int   n;
      logic p;
      n   = 5 + int'(bl);
      pat = '0;
      nb  = 0;
      pat[nb] = 1'b0;
      nb++;
      p = odd;
      for (int i = 0; i < n; i++) begin
         pat[nb] = data[i];
         p = p ^ data[i];
         nb++;
      end
      if (pen) begin
         pat[nb] = p;
         nb++;
      end
      pat[nb] = 1'b1;
      nb++;
   endfunction

   // Precondition: current cycle is idle with Ready=1. Ends in the first idle cycle after the frame.
   // hold = number of frame cycles Start stays high (0 = leave it high).
   task automatic run_frame(input logic [7:0] data, input logic [15:0] div, input logic [1:0] bl,
                            input logic pen, input logic odd, input logic [10:0] pat,
                            input int nb, input int hold, input bit mess, input string name,
                            output int fin_cyc, output int n_shift);
      int         d;
      int         cyc;
      logic [3:0] exp;
      d       = (div == 16'd0) ? 1 : int'(div);
      tx_data = data;
      freq    = div;
      bitlen  = bl;
      par_en  = pen;
      odd_par = odd;
      start   = 1'b1;
      step();
      cyc     = 1;
      fin_cyc = 0;
      n_shift = 0;
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < d; c++) begin
            exp = {pat[b], (c == d - 1), (b == nb - 1) && (c == d - 1), 1'b0};
            check(name, {txd, shclk, fin, rdy}, {28'd0, exp});
            if (shclk) n_shift++;
            if (fin && fin_cyc == 0) fin_cyc = cyc;
            if (cyc == hold) start = 1'b0;
            if (mess && cyc == 3) begin
               en      = 1'b0;
               tx_data = ~data;
               freq    = div + 16'd3;
               bitlen  = ~bl;
               par_en  = ~pen;
               odd_par = ~odd;
            end
            step();
            cyc++;
         end
      end
      check({name, "_idle"}, {txd, shclk, fin, rdy}, {28'd0, 1'b1, 1'b0, 1'b0, en});
   endtask

   initial begin
      int          fin_cyc;
      int          n_shift;
      int          bad;
      logic [10:0] pat;
      int          nb;
      logic [7:0]  rd;
      logic [15:0] rdiv;
      logic [1:0]  rbl;
      logic        rpen;
      logic        rodd;

      vecs[0] = '{8'h38, 16'd32, 2'b11, 1'b0, 1'b0, 12, 11'h270, 10, 320};
      vecs[1] = '{8'h55, 16'd4,  2'b10, 1'b1, 1'b0, 1,  11'h2AA, 10, 40};
      vecs[2] = '{8'h55, 16'd4,  2'b10, 1'b1, 1'b1, 1,  11'h3AA, 10, 40};
      vecs[3] = '{8'h1F, 16'd1,  2'b00, 1'b0, 1'b0, 1,  11'h07E, 7,  7};
      vecs[4] = '{8'h1F, 16'd0,  2'b00, 1'b0, 1'b0, 1,  11'h07E, 7,  7};
      vecs[5] = '{8'hA3, 16'd3,  2'b01, 1'b1, 1'b1, 1,  11'h146, 9,  27};
      vecs[6] = '{8'hFF, 16'd2,  2'b11, 1'b1, 1'b0, 1,  11'h5FE, 11, 22};

      tx_data = '0;
      freq    = '0;
      bitlen  = '0;
      par_en  = 1'b0;
      odd_par = 1'b0;
      en      = 1'b1;
      start   = 1'b0;
      p_reset = 1'b1;

      step();
      check("reset_state", {txd, shclk, fin, rdy}, 32'b1000);
      p_reset = 1'b0;
      step();
      check("post_reset_ready", {txd, shclk, fin, rdy}, 32'b1001);

      // Table of known frames.
      foreach (vecs[i]) begin
         run_frame(vecs[i].data, vecs[i].div, vecs[i].bl, vecs[i].pen, vecs[i].odd, vecs[i].pat,
                   vecs[i].nb, vecs[i].hold, 1'b0, $sformatf("vec%0d", i), fin_cyc, n_shift);
         check($sformatf("vec%0d_len", i), fin_cyc, vecs[i].len);
         check($sformatf("vec%0d_shifts", i), n_shift, vecs[i].nb);
         if (i == 0) begin
            bad = 0;
            for (int c = 0; c < 40; c++) begin
               if (txd !== 1'b1 || rdy !== 1'b1 || fin !== 1'b0) bad++;
               step();
            end
            check("one_frame_only", bad, 0);
         end
      end

      // Enable low blocks starts.
      en    = 1'b0;
      start = 1'b0;
      step();
      check("disable_ready", {txd, shclk, fin, rdy}, 32'b1000);
      start = 1'b1;
      bad   = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if ({txd, shclk, fin, rdy} !== 4'b1000) bad++;
      end
      check("disabled_no_start", bad, 0);
      start = 1'b0;
      en    = 1'b1;
      step();
      check("reenable_ready", {txd, shclk, fin, rdy}, 32'b1001);

      // Enable and config inputs change mid-frame; the latched frame must complete unchanged.
      build_pat(8'hC6, 2'b11, 1'b1, 1'b1, pat, nb);
      run_frame(8'hC6, 16'd3, 2'b11, 1'b1, 1'b1, pat, nb, 1, 1'b1, "mid_change", fin_cyc, n_shift);
      check("mid_change_len", fin_cyc, nb * 3);
      en = 1'b1;
      step();
      check("mid_change_reenable", {txd, shclk, fin, rdy}, 32'b1001);

      // Start held continuously: two frames separated by one Ready cycle.
      build_pat(8'h9A, 2'b11, 1'b0, 1'b0, pat, nb);
      run_frame(8'h9A, 16'd8, 2'b11, 1'b0, 1'b0, pat, nb, 0, 1'b0, "b2b_first", fin_cyc, n_shift);
      run_frame(8'h9A, 16'd8, 2'b11, 1'b0, 1'b0, pat, nb, 0, 1'b0, "b2b_second", fin_cyc, n_shift);
      check("b2b_len", fin_cyc, nb * 8);
      start = 1'b0;
      step();
      check("b2b_stopped", {txd, shclk, fin, rdy}, 32'b1001);

      // Reset in the middle of the data bits.
      tx_data = 8'hAA;
      freq    = 16'd4;
      bitlen  = 2'b11;
      par_en  = 1'b0;
      odd_par = 1'b0;
      start   = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 6; c++) step();
      check("pre_reset_databit", {txd, rdy}, 32'b00);
      p_reset = 1'b1;
      step();
      check("mid_reset_state", {txd, shclk, fin, rdy}, 32'b1000);
      p_reset = 1'b0;
      step();
      check("mid_reset_release", {txd, shclk, fin, rdy}, 32'b1001);
      bad = 0;
      for (int c = 0; c < 40; c++) begin
         if (txd !== 1'b1 || fin !== 1'b0 || shclk !== 1'b0) bad++;
         step();
      end
      check("mid_reset_aborted", bad, 0);

      // Randomized frames against the reference model.
      for (int k = 0; k < 40; k++) begin
         rd   = 8'($urandom);
         rdiv = 16'($urandom_range(0, 6));
         rbl  = 2'($urandom);
         rpen = 1'($urandom);
         rodd = 1'($urandom);
         build_pat(rd, rbl, rpen, rodd, pat, nb);
         run_frame(rd, rdiv, rbl, rpen, rodd, pat, nb, int'($urandom_range(1, 3)), 1'b0,
                   $sformatf("rand%0d", k), fin_cyc, n_shift);
         check($sformatf("rand%0d_len", k), fin_cyc, nb * ((rdiv == 16'd0) ? 1 : int'(rdiv)));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 1000000");
      $fatal(1, "watchdog expired");
   end

endmodule
